// File: rtl/seven_seg_capture.sv
// Recovers the hex digits shown on a multiplexed, active-low 7-segment display
// by waiting for each {an, seg} pair to hold steady. Optional illegal-capture
// counter: define SEG_CAPTURE_ERR_EN.
module seven_seg_capture #(
  parameter int unsigned STABLE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seg,
  input  logic [3:0] an,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] dp,
  output logic [3:0] dvalid,
  output logic       upd,
  output logic [7:0] err_cnt
);

  localparam logic [3:0] STABLE_MAX = 4'(STABLE_CNT);

  typedef struct packed {
    logic       ok;
    logic [3:0] val;
  } dec_t;

  function automatic dec_t decode(input logic [6:0] s);
    dec_t r;
    r.ok = 1'b1;
    case (s)
      7'h40: r.val = 4'h0;
      7'h79: r.val = 4'h1;
      7'h24: r.val = 4'h2;
      7'h30: r.val = 4'h3;
      7'h19: r.val = 4'h4;
      7'h12: r.val = 4'h5;
      7'h02: r.val = 4'h6;
      7'h78: r.val = 4'h7;
      7'h00: r.val = 4'h8;
      7'h10: r.val = 4'h9;
      7'h08: r.val = 4'hA;
      7'h03: r.val = 4'hB;
      7'h46: r.val = 4'hC;
      7'h21: r.val = 4'hD;
      7'h06: r.val = 4'hE;
      7'h0E: r.val = 4'hF;
      default: begin
        r.ok  = 1'b0;
        r.val = 4'h0;
      end
    endcase
    return r;
  endfunction

  logic [7:0]       seg_s1_q, seg_s2_q;
  logic [3:0]       an_s1_q, an_s2_q;
  logic [11:0]      pair_q, pair_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             cap_q, cap_d;
  logic [3:0][3:0]  digit_q, digit_d;
  logic [3:0]       dp_q, dp_d;
  logic [3:0]       dvalid_q, dvalid_d;
  logic             upd_q, upd_d;

  logic [3:0]       an_cap;
  logic [7:0]       seg_cap;
  logic             sel_ok;
  logic [1:0]       sel_idx;
  dec_t             dec;

  assign an_cap  = pair_q[11:8];
  assign seg_cap = pair_q[7:0];
  assign dec     = decode(seg_cap[6:0]);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pair_d = {an_s2_q, seg_s2_q};
    if (pair_d != pair_q)          cnt_d = 4'd1;
    else if (cnt_q == STABLE_MAX)  cnt_d = cnt_q;
    else                           cnt_d = cnt_q + 4'd1;
    cap_d = (cnt_d == STABLE_MAX) && (cnt_q != STABLE_MAX);
  end

  always_comb begin
    sel_ok  = 1'b1;
    sel_idx = 2'd0;
    case (an_cap)
      4'b1110: sel_idx = 2'd0;
      4'b1101: sel_idx = 2'd1;
      4'b1011: sel_idx = 2'd2;
      4'b0111: sel_idx = 2'd3;
      default: sel_ok  = 1'b0;
    endcase
  end

  // The capture stage works from pair_q, which still holds the pair that just became stable.
  always_comb begin
    digit_d  = digit_q;
    dp_d     = dp_q;
    dvalid_d = dvalid_q;
    upd_d    = 1'b0;
    if (cap_q && sel_ok && dec.ok) begin
      digit_d[sel_idx]  = dec.val;
      dp_d[sel_idx]     = ~seg_cap[7];
      dvalid_d[sel_idx] = 1'b1;
      upd_d = !dvalid_q[sel_idx] || (digit_q[sel_idx] != dec.val) ||
              (dp_q[sel_idx] != ~seg_cap[7]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_s1_q <= '0;
      seg_s2_q <= '0;
      an_s1_q  <= '0;
      an_s2_q  <= '0;
      pair_q   <= '1;
      cnt_q    <= '0;
      cap_q    <= 1'b0;
      digit_q  <= '0;
      dp_q     <= '0;
      dvalid_q <= '0;
      upd_q    <= 1'b0;
    end else begin
      seg_s1_q <= seg;
      seg_s2_q <= seg_s1_q;
      an_s1_q  <= an;
      an_s2_q  <= an_s1_q;
      pair_q   <= pair_d;
      cnt_q    <= cnt_d;
      cap_q    <= cap_d;
      digit_q  <= digit_d;
      dp_q     <= dp_d;
      dvalid_q <= dvalid_d;
      upd_q    <= upd_d;
    end
  end

  assign digit0 = digit_q[0];
  assign digit1 = digit_q[1];
  assign digit2 = digit_q[2];
  assign digit3 = digit_q[3];
  assign dp     = dp_q;
  assign dvalid = dvalid_q;
  assign upd    = upd_q;

`ifdef SEG_CAPTURE_ERR_EN
  logic [7:0] err_q, err_d;
  logic       blank;
  logic       illegal;

  // A blank display (all anodes off) is not an error, whatever seg shows.
  always_comb begin
    blank   = (an_cap == 4'b1111);
    illegal = cap_q && !blank && !(sel_ok && dec.ok);
    err_d   = err_q;
    if (illegal && (err_q != 8'hFF)) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture (STABLE_CNT = 4); error-count
// expectations follow SEG_CAPTURE_ERR_EN.
module tb_seven_seg_capture;

`ifdef SEG_CAPTURE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] seg = 8'hC0;
  logic [3:0] an  = 4'b1110;
  logic [3:0] digit0, digit1, digit2, digit3, dp, dvalid;
  logic       upd;
  logic [7:0] err_cnt;

  int n_total = 0;
  int n_bad   = 0;
  int upd_seen = 0;

  seven_seg_capture #(.STABLE_CNT(4)) dut (
    .clk(clk), .rst(rst), .seg(seg), .an(an),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .dp(dp), .dvalid(dvalid), .upd(upd), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (upd === 1'b1) upd_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] digits();
    return {digit3, digit2, digit1, digit0};
  endfunction

  logic [3:0] rot_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [7:0] rot_seg [4] = '{8'hF9, 8'hA4, 8'hB0, 8'h99};

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_digits", 32'(digits()), 32'h0);
    check("rst_dp_dvalid", {24'h0, dp, dvalid}, 32'h0);
    check("rst_upd", 32'(upd), 32'h0);
    check("rst_err", 32'(err_cnt), 32'h0);

    // First capture latency: digit 0 shows '0' after edge 7
    rst = 1'b0;
    hold(4'b1110, 8'hC0, 6);
    check("lat_edge6_dvalid", 32'(dvalid), 32'h0);
    hold(4'b1110, 8'hC0, 1);
    check("lat_edge7_dvalid", 32'(dvalid), 32'h1);
    check("lat_edge7_digit0", 32'(digit0), 32'h0);
    check("lat_edge7_dp", 32'(dp), 32'h0);
    check("lat_edge7_upd", 32'(upd), 32'h1);
    hold(4'b1110, 8'hC0, 1);
    check("lat_edge8_upd", 32'(upd), 32'h0);

    // Rotation 1..4, then identical rotation
    upd_seen = 0;
    for (int i = 0; i < 4; i++) hold(rot_an[i], rot_seg[i], 8);
    check("rot_digits", 32'(digits()), 32'h4321);
    check("rot_dvalid", 32'(dvalid), 32'hF);
    check("rot_dp", 32'(dp), 32'h0);
    check("rot_upd_cnt", upd_seen, 4);
    upd_seen = 0;
    for (int i = 0; i < 4; i++) hold(rot_an[i], rot_seg[i], 8);
    check("rerot_upd_cnt", upd_seen, 0);

    // Short '5' then held '6' on digit 1: only the 6 lands
    upd_seen = 0;
    hold(4'b1101, 8'h92, 3);
    hold(4'b1101, 8'h82, 8);
    check("restart_digits", 32'(digits()), 32'h4361);
    check("restart_upd_cnt", upd_seen, 1);

    // Same value on digit 3, decimal point turned on
    upd_seen = 0;
    hold(4'b0111, 8'h19, 8);
    check("dp_on", 32'(dp), 32'h8);
    check("dp_digit3", 32'(digit3), 32'h4);
    check("dp_upd_cnt", upd_seen, 1);

    // Two illegal captures: bad anode, then bad pattern
    upd_seen = 0;
    hold(4'b1100, 8'hFF, 8);
    hold(4'b1110, 8'h7F, 8);
    check("err_two", 32'(err_cnt), ERR_EN ? 32'd2 : 32'd0);
    check("err_digits", 32'(digits()), 32'h4361);
    check("err_dvalid", 32'(dvalid), 32'hF);
    check("err_upd_cnt", upd_seen, 0);

    // Blank display held long
    hold(4'b1111, 8'hFF, 20);
    check("blank_err", 32'(err_cnt), ERR_EN ? 32'd2 : 32'd0);
    check("blank_upd_cnt", upd_seen, 0);

    // Saturation after 300 illegal events
    for (int i = 0; i < 150; i++) begin
      hold(4'b1100, 8'hFF, 6);
      hold(4'b1010, 8'hFF, 6);
    end
    check("err_sat", 32'(err_cnt), ERR_EN ? 32'd255 : 32'd0);
    check("sat_digits", 32'(digits()), 32'h4361);

    // Reset in the middle of a valid hold, then full latency again
    hold(4'b1110, 8'hA4, 4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_digits", 32'(digits()), 32'h0);
    check("midrst_flags", {23'h0, upd, dp, dvalid}, 32'h0);
    check("midrst_err", 32'(err_cnt), 32'h0);
    rst = 1'b0;
    hold(4'b1110, 8'hA4, 6);
    check("post_rst_edge6_dvalid", 32'(dvalid), 32'h0);
    hold(4'b1110, 8'hA4, 1);
    check("post_rst_edge7_dvalid", 32'(dvalid), 32'h1);
    check("post_rst_edge7_digit0", 32'(digit0), 32'h2);
    check("post_rst_edge7_upd", 32'(upd), 32'h1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
